// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 writeback stage: W register, register file, status and retire counter
module writeback_stage #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic [1:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic [1:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic              W_valid,
    output logic [1:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] NREG_ID = 4'(NREG);

    logic [1:0]        w_stat_q,  w_stat_d;
    logic [3:0]        w_icode_q, w_icode_d;
    logic [DATA_W-1:0] w_valE_q,  w_valE_d;
    logic [DATA_W-1:0] w_valM_q,  w_valM_d;
    logic [3:0]        w_dstE_q,  w_dstE_d;
    logic [3:0]        w_dstM_q,  w_dstM_d;
    logic              w_valid_q, w_valid_d;
    logic [1:0]        stat_q,    stat_d;
    logic              halted_q,  halted_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic [DATA_W-1:0] rf_q [NREG];

    logic commit;
    logic fault;
    logic freeze;
    logic wr_ok;
    logic we_e;
    logic we_m;

    assign commit = w_valid_q && !halted_q;
    assign fault  = commit && (w_stat_q != 2'd0);
    assign freeze = halted_q || fault;
    assign wr_ok  = commit && (w_stat_q == 2'd0);

    // popq %rsp: when both destinations name the same register, valM wins
    assign we_m = wr_ok && (w_dstM_q != RNONE) && (w_dstM_q < NREG_ID);
    assign we_e = wr_ok && (w_dstE_q != RNONE) && (w_dstE_q < NREG_ID)
                  && (w_dstE_q != w_dstM_q);

    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_valE_d  = w_valE_q;
        w_valM_d  = w_valM_q;
        w_dstE_d  = w_dstE_q;
        w_dstM_d  = w_dstM_q;
        w_valid_d = w_valid_q;
        if (freeze) begin
            w_valid_d = w_valid_q;
        end else if (W_stall) begin
            w_valid_d = 1'b0;
        end else if (W_bubble) begin
            w_stat_d  = 2'd0;
            w_icode_d = I_NOP;
            w_valE_d  = '0;
            w_valM_d  = '0;
            w_dstE_d  = RNONE;
            w_dstM_d  = RNONE;
            w_valid_d = 1'b0;
        end else begin
            w_stat_d  = m_stat;
            w_icode_d = m_icode;
            w_valE_d  = m_valE;
            w_valM_d  = m_valM;
            w_dstE_d  = m_dstE;
            w_dstM_d  = m_dstM;
            w_valid_d = 1'b1;
        end
    end

    always_comb begin
        stat_d   = stat_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (fault) begin
            stat_d   = w_stat_q;
            halted_d = 1'b1;
        end
        if (wr_ok && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_stat_q  <= 2'd0;
            w_icode_q <= I_NOP;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_dstE_q  <= RNONE;
            w_dstM_q  <= RNONE;
            w_valid_q <= 1'b0;
            stat_q    <= 2'd0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_valE_q  <= w_valE_d;
            w_valM_q  <= w_valM_d;
            w_dstE_q  <= w_dstE_d;
            w_dstM_q  <= w_dstM_d;
            w_valid_q <= w_valid_d;
            stat_q    <= stat_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (we_e) begin
                rf_q[w_dstE_q] <= w_valE_q;
            end
            if (we_m) begin
                rf_q[w_dstM_q] <= w_valM_q;
            end
        end
    end

    assign d_rvalA = (d_srcA < NREG_ID) ? rf_q[d_srcA] : '0;
    assign d_rvalB = (d_srcB < NREG_ID) ? rf_q[d_srcB] : '0;

    assign W_stat       = w_stat_q;
    assign W_icode      = w_icode_q;
    assign W_valE       = w_valE_q;
    assign W_valM       = w_valM_q;
    assign W_dstE       = w_dstE_q;
    assign W_dstM       = w_dstM_q;
    assign W_valid      = w_valid_q;
    assign stat         = stat_q;
    assign halted       = halted_q;
    assign retire_count = cnt_q;

endmodule
